// File: rtl/writeback_arbiter.sv
// Two-requester writeback arbiter: ALU and load results compete for one register
// file write port, with alternating priority on conflict and a registered write stage.
module writeback_arbiter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         alu_valid_i,
  input  logic [4:0]   alu_addr_i,
  input  logic [N-1:0] alu_data_i,
  output logic         alu_ready_o,
  input  logic         mem_valid_i,
  input  logic [4:0]   mem_addr_i,
  input  logic [N-1:0] mem_data_i,
  output logic         mem_ready_o,
  input  logic         freeze_i,
  output logic [4:0]   Write_Register_o,
  output logic [N-1:0] Write_Data_o,
  output logic         Reg_Write_o,
  output logic [31:0]  Decoder_Out,
  output logic [15:0]  conflict_count_o,
  output logic         prio_state_o
);

  // Handshake: a request transfers on a rising edge where its valid and ready are
  // both high; the requester holds addr/data while valid is high and ready is low.
  // Ready is combinational and never depends on ready itself.

  typedef enum logic {
    PRIO_MEM = 1'b0,
    PRIO_ALU = 1'b1
  } prio_e;

  prio_e          state_q, state_d;
  logic [4:0]     wr_addr_q, wr_addr_d;
  logic [N-1:0]   wr_data_q, wr_data_d;
  logic           wr_en_q, wr_en_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           alu_grant, mem_grant, both_valid;

  always_comb begin
    both_valid = alu_valid_i & mem_valid_i;
    alu_grant  = !reset && !freeze_i && alu_valid_i &&
                 (!mem_valid_i || (state_q == PRIO_ALU));
    mem_grant  = !reset && !freeze_i && mem_valid_i &&
                 (!alu_valid_i || (state_q == PRIO_MEM));

    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    if (alu_grant) begin
      state_d   = PRIO_MEM;
      wr_addr_d = alu_addr_i;
      wr_data_d = alu_data_i;
      wr_en_d   = |alu_addr_i;
    end else if (mem_grant) begin
      state_d   = PRIO_ALU;
      wr_addr_d = mem_addr_i;
      wr_data_d = mem_data_i;
      wr_en_d   = |mem_addr_i;
    end

    // Conflicts are counted even while frozen; the counter sticks at all-ones.
    cnt_d = cnt_q;
    if (both_valid && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= PRIO_MEM;
      wr_addr_q <= 5'd0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      cnt_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    alu_ready_o      = alu_grant;
    mem_ready_o      = mem_grant;
    Write_Register_o = wr_addr_q;
    Write_Data_o     = wr_data_q;
    Reg_Write_o      = wr_en_q;
    Decoder_Out      = wr_en_q ? (32'd1 << wr_addr_q) : 32'd0;
    conflict_count_o = cnt_q;
    prio_state_o     = state_q;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus random traffic, all checked
// against a grant/write model built from the arbitration rules.
module tb_writeback_arbiter;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         alu_valid_i = 1'b0;
  logic [4:0]   alu_addr_i = '0;
  logic [N-1:0] alu_data_i = '0;
  logic         alu_ready_o;
  logic         mem_valid_i = 1'b0;
  logic [4:0]   mem_addr_i = '0;
  logic [N-1:0] mem_data_i = '0;
  logic         mem_ready_o;
  logic         freeze_i = 1'b0;
  logic [4:0]   Write_Register_o;
  logic [N-1:0] Write_Data_o;
  logic         Reg_Write_o;
  logic [31:0]  Decoder_Out;
  logic [15:0]  conflict_count_o;
  logic         prio_state_o;

  writeback_arbiter #(.N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_valid_i      (alu_valid_i),
    .alu_addr_i       (alu_addr_i),
    .alu_data_i       (alu_data_i),
    .alu_ready_o      (alu_ready_o),
    .mem_valid_i      (mem_valid_i),
    .mem_addr_i       (mem_addr_i),
    .mem_data_i       (mem_data_i),
    .mem_ready_o      (mem_ready_o),
    .freeze_i         (freeze_i),
    .Write_Register_o (Write_Register_o),
    .Write_Data_o     (Write_Data_o),
    .Reg_Write_o      (Reg_Write_o),
    .Decoder_Out      (Decoder_Out),
    .conflict_count_o (conflict_count_o),
    .prio_state_o     (prio_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model state ----------------
  int checks = 0;
  int failures = 0;

  logic [36:0]  exp_q[$];        // {addr, data} of writes that must strobe
  bit           m_we;
  logic [4:0]   m_addr;
  logic [N-1:0] m_data;
  int           m_cnt;
  bit           m_last_alu;      // last granted requester was the ALU
  bit           g_alu, g_mem;    // model grants at the most recent edge
  logic         obs_alu_rdy, obs_mem_rdy;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_we = 0; m_addr = '0; m_data = '0; m_cnt = 0; m_last_alu = 1;
    exp_q.delete();
  endtask

  // Both valid: serve whoever was not served last. Alone: always served.
  task automatic model_grant(output bit ga, output bit gm);
    ga = 0; gm = 0;
    if (!reset && !freeze_i) begin
      if (alu_valid_i && mem_valid_i) begin
        if (m_last_alu) gm = 1; else ga = 1;
      end else if (alu_valid_i) ga = 1;
      else if (mem_valid_i) gm = 1;
    end
  endtask

  // One clock: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit ga, gm;
    logic [31:0] one;
    logic [31:0] exp_dec;
    logic [36:0] w;
    one = 32'd1;
    @(negedge clk);
    model_grant(ga, gm);
    obs_alu_rdy = alu_ready_o;
    obs_mem_rdy = mem_ready_o;
    exp_dec = m_we ? (one << m_addr) : 32'd0;
    check_val("alu_ready", alu_ready_o, ga);
    check_val("mem_ready", mem_ready_o, gm);
    check_val("reg_write", Reg_Write_o, m_we);
    check_val("decoder", Decoder_Out, exp_dec);
    check_val("wr_reg", Write_Register_o, m_addr);
    check_val("wr_data", Write_Data_o, m_data);
    check_val("conflict_cnt", conflict_count_o, m_cnt);
    check_val("prio_state", prio_state_o, !m_last_alu);
    if (m_we) begin
      if (exp_q.size() == 0) check_val("sb_empty", 1, 0);
      else begin
        w = exp_q.pop_front();
        check_val("sb_write", {Write_Register_o, Write_Data_o}, w);
      end
    end
    @(posedge clk);
    if (alu_valid_i && mem_valid_i && m_cnt < 65535) m_cnt++;
    m_we = 0;
    if (ga) begin
      m_addr = alu_addr_i; m_data = alu_data_i; m_we = (alu_addr_i != 0); m_last_alu = 1;
    end else if (gm) begin
      m_addr = mem_addr_i; m_data = mem_data_i; m_we = (mem_addr_i != 0); m_last_alu = 0;
    end
    if (m_we) exp_q.push_back({m_addr, m_data});
    g_alu = ga; g_mem = gm;
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check_val("rst_reg_write", Reg_Write_o, 0);
    check_val("rst_decoder", Decoder_Out, 0);
    check_val("rst_wr_reg", Write_Register_o, 0);
    check_val("rst_wr_data", Write_Data_o, 0);
    check_val("rst_cnt", conflict_count_o, 0);
    check_val("rst_readies", {alu_ready_o, mem_ready_o}, 0);
    check_val("rst_prio", prio_state_o, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    alu_valid_i = 0; mem_valid_i = 0; freeze_i = 0;
    model_reset();
  endtask

  task automatic drive_alu(input bit v, input logic [4:0] a, input logic [N-1:0] d);
    alu_valid_i = v; alu_addr_i = a; alu_data_i = d;
  endtask

  task automatic drive_mem(input bit v, input logic [4:0] a, input logic [N-1:0] d);
    mem_valid_i = v; mem_addr_i = a; mem_data_i = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int alt_err;
    bit prev_alu;
    model_reset();
    g_alu = 0; g_mem = 0;
    #2;
    apply_reset();

    // Both valid after reset: mem first, then alu; first edge after reset accepts.
    drive_alu(1, 5'd3, 32'hAAAA);
    drive_mem(1, 5'd5, 32'h5555);
    step();
    check_val("c1_mem_rdy", obs_mem_rdy, 1);
    check_val("c1_reg_write", Reg_Write_o, 1);
    check_val("c1_wr_reg", Write_Register_o, 5);
    check_val("c1_decoder", Decoder_Out, 32'h20);
    drive_mem(0, 5'd0, '0);
    step();
    check_val("c2_alu_rdy", obs_alu_rdy, 1);
    check_val("c2_wr_reg", Write_Register_o, 3);
    check_val("c2_decoder", Decoder_Out, 32'h8);
    check_val("c2_cnt", conflict_count_o, 1);
    drive_alu(0, 5'd0, '0);
    step();

    // ALU alone to r31, three back-to-back transfers.
    drive_alu(1, 5'd31, 32'h1234);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("b2b_alu_rdy", obs_alu_rdy, 1);
      check_val("b2b_reg_write", Reg_Write_o, 1);
      check_val("b2b_decoder", Decoder_Out, 32'h8000_0000);
    end
    drive_alu(0, 5'd0, '0);
    step();

    // Load to r0: accepted but no strobe; data still lands.
    drive_mem(1, 5'd0, 32'hFFFF);
    step();
    check_val("r0_mem_rdy", obs_mem_rdy, 1);
    check_val("r0_reg_write", Reg_Write_o, 0);
    check_val("r0_decoder", Decoder_Out, 0);
    check_val("r0_wr_data", Write_Data_o, 32'hFFFF);
    drive_mem(0, 5'd0, '0);
    step();

    // Freeze with both valid for four cycles, then release.
    apply_reset();
    step();
    base = conflict_count_o;
    drive_alu(1, 5'd9, 32'h9999);
    drive_mem(1, 5'd10, 32'hA0A0);
    freeze_i = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_val("frz_readies", {obs_alu_rdy, obs_mem_rdy}, 0);
      check_val("frz_reg_write", Reg_Write_o, 0);
    end
    check_val("frz_cnt_delta", conflict_count_o - base, 4);
    freeze_i = 0;
    step();
    check_val("frz_first_mem", obs_mem_rdy, 1);
    check_val("frz_first_reg", Write_Register_o, 10);
    drive_alu(0, 5'd0, '0);
    drive_mem(0, 5'd0, '0);
    step();

    // Reset between a grant and its write: the write is discarded.
    drive_alu(1, 5'd7, 32'h7777);
    step();
    check_val("mid_pre_strobe", Reg_Write_o, 1);
    drive_alu(0, 5'd0, '0);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("mid_post_strobe", Reg_Write_o, 0);
    end

    // Random traffic with holds, freezes and address 0.
    for (int i = 0; i < 3000; i++) begin
      if (!alu_valid_i || g_alu)
        drive_alu($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      if (!mem_valid_i || g_mem)
        drive_mem($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
      freeze_i = ($urandom_range(0, 7) == 0);
      step();
    end
    freeze_i = 0;

    // Sustained conflict: counter saturates, grants alternate every cycle.
    apply_reset();
    drive_alu(1, 5'd1, $urandom);
    drive_mem(1, 5'd2, $urandom);
    alt_err = 0;
    prev_alu = 1;
    for (int i = 0; i < 70000; i++) begin
      step();
      if (obs_alu_rdy == prev_alu || obs_alu_rdy == obs_mem_rdy) alt_err++;
      prev_alu = obs_alu_rdy;
      if (g_alu) alu_data_i = $urandom;
      if (g_mem) mem_data_i = $urandom;
    end
    check_val("sat_alternation_errs", alt_err, 0);
    check_val("sat_cnt", conflict_count_o, 16'hFFFF);
    drive_alu(0, 5'd0, '0);
    drive_mem(0, 5'd0, '0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter N, default 32: width of write data.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 alu_valid_i  input  1  ALU requester has a writeback pending.
REQ-005 alu_addr_i  input  5  ALU destination register.
REQ-006 alu_data_i  input  N  ALU writeback data.
REQ-007 alu_ready_o  output  1  ALU request accepted this cycle.
REQ-008 mem_valid_i  input  1  load requester has a writeback pending.
REQ-009 mem_addr_i  input  5  load destination register.
REQ-010 mem_data_i  input  N  load writeback data.
REQ-011 mem_ready_o  output  1  load request accepted this cycle.
REQ-012 freeze_i  input  1  blocks all new grants while high.
REQ-013 Write_Register_o  output  5  register file write address.
REQ-014 Write_Data_o  output  N  register file write data.
REQ-015 Reg_Write_o  output  1  register file write strobe, one cycle per write.
REQ-016 Decoder_Out  output  32  one-hot write enable for Write_Register_o, gated by Reg_Write_o.
REQ-017 conflict_count_o  output  16  count of cycles in which both requesters were valid.

Function
REQ-018 Handshake: a transfer occurs on a rising edge when valid and ready are both high. Requesters hold addr/data stable while valid is high and ready is low.
REQ-019 Ready is combinational from valid, the priority state and freeze_i. At most one of alu_ready_o/mem_ready_o is high in any cycle.
REQ-020 A ready is high only when its own valid is high.
REQ-021 Priority FSM has two states: PRIO_MEM and PRIO_ALU. Reset state is PRIO_MEM.
REQ-022 Only one valid, freeze_i low: that requester is granted regardless of FSM state.
REQ-023 Both valid, freeze_i low: the requester named by the FSM state is granted.
REQ-024 After any grant, the FSM moves to the state favouring the non-granted requester. With no grant, the FSM holds.
REQ-025 freeze_i high: both readies low and the FSM holds. An output already registered still completes.
REQ-026 Output stage is registered, giving one-cycle latency. A transfer at edge t drives Write_Register_o, Write_Data_o and Reg_Write_o=1 during cycle t+1.
REQ-027 In a cycle following no transfer, Reg_Write_o=0 and Decoder_Out=0. Write_Register_o and Write_Data_o hold their last values.
REQ-028 A transfer to address 0 is accepted (ready high) but produces Reg_Write_o=0 and Decoder_Out=0. Write_Register_o and Write_Data_o still update.
REQ-029 Decoder_Out = (1 << Write_Register_o) when Reg_Write_o=1, else 0.
REQ-030 Back-to-back transfers are supported, with one write per cycle and no bubble.
REQ-031 conflict_count_o increments on each edge where alu_valid_i and mem_valid_i are both high, including under freeze_i. It saturates at 16'hFFFF.

Reset
REQ-032 While reset is high, the following values hold immediately, without waiting for clk:
- FSM = PRIO_MEM.
- Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, Decoder_Out=0.
- conflict_count_o=0.
- Both readies are 0 while reset is high.
REQ-033 Reset asserted mid-transfer discards the pending output write. No strobe is issued after reset deasserts.
REQ-034 The first edge after reset deassertion may accept a transfer.

Verification
REQ-035 Reset, then both valid (alu addr 3, data 0xAAAA; mem addr 5, data 0x5555), both held for 2 cycles. Required:
- Cycle 1: mem granted; next cycle Reg_Write_o=1, Write_Register_o=5, Decoder_Out=0x00000020.
- Cycle 2: alu granted; next cycle Write_Register_o=3, Decoder_Out=0x00000008.
- conflict_count_o=1 after the single both-valid edge.
REQ-036 alu_valid_i only, addr 31, data 0x1234, for 3 consecutive transfers. Required: alu_ready_o high every cycle; Reg_Write_o high for 3 consecutive cycles with Decoder_Out=0x80000000.
REQ-037 mem_valid_i, addr 0, data 0xFFFF. Required: mem_ready_o=1; next cycle Reg_Write_o=0, Decoder_Out=0, Write_Data_o=0xFFFF.
REQ-038 freeze_i=1 with both valid for 4 cycles, then freeze_i=0. Required:
- During freeze: readies 0, Reg_Write_o=0, conflict_count_o advances by 4.
- First grant after release goes to mem.
REQ-039 Grant to alu at edge t; reset asserted between edges t and t+1. Required: Reg_Write_o=0 immediately and stays 0 after reset deasserts.
REQ-040 Hold both valid for 70000 cycles. Required: conflict_count_o saturates at 0xFFFF; grants alternate every cycle.
